// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared score limits, rally timing defaults and round state encoding
package score_pkg;
  localparam int MAX_SCORE          = 7;
  localparam int MAX_SCORE_W        = $clog2(MAX_SCORE + 1);
  localparam int SERVE_DELAY_FRAMES = 60;
  localparam int POINT_HOLD_FRAMES  = 30;

  typedef enum logic [1:0] {
    RND_IDLE,
    RND_SERVE,
    RND_PLAY,
    RND_POINT
  } rnd_state_e;
endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable frame down-counter shared by the serve and point holds
module frame_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  // load wins over tick, so a tick on the entry edge is never counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0) & tick;
endmodule

// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - rally sequencer: serve countdown, play, point hold, score keeping
module round_ctrl #(
  parameter int SERVE_DELAY_FRAMES = score_pkg::SERVE_DELAY_FRAMES,
  parameter int POINT_HOLD_FRAMES  = score_pkg::POINT_HOLD_FRAMES
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            game_en_i,
  input  logic                            frame_tick_i,
  input  logic                            miss_left_i,
  input  logic                            miss_right_i,
  output logic [score_pkg::MAX_SCORE_W-1:0] p_score_o,
  output logic [score_pkg::MAX_SCORE_W-1:0] e_score_o,
  output logic                            ball_rst_o,
  output logic                            ball_en_o,
  output logic                            serve_dir_o
);
  import score_pkg::*;

  localparam int CNT_MAX = (SERVE_DELAY_FRAMES > POINT_HOLD_FRAMES) ?
                           SERVE_DELAY_FRAMES : POINT_HOLD_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]       SERVE_LOAD = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0]       HOLD_LOAD  = CNT_W'(POINT_HOLD_FRAMES - 1);
  localparam logic [MAX_SCORE_W-1:0] SCORE_MAX  = MAX_SCORE_W'(MAX_SCORE);

  rnd_state_e       state, state_next;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tick;
  logic             tmr_done;
  logic             score_clr;
  logic             inc_p;
  logic             inc_e;
  logic             dir_set;
  logic             dir_val;

  assign tmr_tick = frame_tick_i & ((state == RND_SERVE) | (state == RND_POINT));

  frame_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tick    (tmr_tick),
    .done    (tmr_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RND_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    score_clr  = 1'b0;
    inc_p      = 1'b0;
    inc_e      = 1'b0;
    dir_set    = 1'b0;
    dir_val    = serve_dir_o;
    if (!game_en_i) begin
      state_next = RND_IDLE;
    end else begin
      case (state)
        RND_IDLE: begin
          score_clr  = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = SERVE_LOAD;
          state_next = RND_SERVE;
        end
        RND_SERVE: begin
          if (tmr_done) state_next = RND_PLAY;
        end
        RND_PLAY: begin
          if (miss_left_i || miss_right_i) begin
            inc_e      = miss_left_i;
            inc_p      = miss_right_i;
            // a double miss has no loser to serve toward, so direction is kept
            dir_set    = miss_left_i ^ miss_right_i;
            dir_val    = miss_right_i;
            tmr_load   = 1'b1;
            tmr_val    = HOLD_LOAD;
            state_next = RND_POINT;
          end
        end
        RND_POINT: begin
          if (tmr_done) begin
            if (p_score_o == SCORE_MAX || e_score_o == SCORE_MAX) begin
              state_next = RND_IDLE;
            end else begin
              tmr_load   = 1'b1;
              tmr_val    = SERVE_LOAD;
              state_next = RND_SERVE;
            end
          end
        end
        default: state_next = RND_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_score_o   <= '0;
      e_score_o   <= '0;
      serve_dir_o <= 1'b0;
    end else if (score_clr) begin
      p_score_o   <= '0;
      e_score_o   <= '0;
      serve_dir_o <= 1'b0;
    end else begin
      if (inc_p && p_score_o != SCORE_MAX) p_score_o <= p_score_o + 1'b1;
      if (inc_e && e_score_o != SCORE_MAX) e_score_o <= e_score_o + 1'b1;
      if (dir_set) serve_dir_o <= dir_val;
    end
  end

  assign ball_rst_o = (state == RND_IDLE) | (state == RND_SERVE);
  assign ball_en_o  = (state == RND_PLAY);
endmodule

// File: tb/tb_round_ctrl.sv
// tb/tb_round_ctrl.sv - vector table plus rally sequences checked through an expectation queue
module tb_round_ctrl;
  import score_pkg::*;

  localparam int SD = 3;
  localparam int PH = 2;
  localparam int W  = MAX_SCORE_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         game_en;
  logic         frame_tick;
  logic         miss_left;
  logic         miss_right;
  logic [W-1:0] p_score;
  logic [W-1:0] e_score;
  logic         ball_rst;
  logic         ball_en;
  logic         serve_dir;

  always #5 clk = ~clk;

  round_ctrl #(
    .SERVE_DELAY_FRAMES(SD),
    .POINT_HOLD_FRAMES (PH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .game_en_i   (game_en),
    .frame_tick_i(frame_tick),
    .miss_left_i (miss_left),
    .miss_right_i(miss_right),
    .p_score_o   (p_score),
    .e_score_o   (e_score),
    .ball_rst_o  (ball_rst),
    .ball_en_o   (ball_en),
    .serve_dir_o (serve_dir)
  );

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] e;
    logic         r;
    logic         be;
    logic         d;
  } exp_t;

  typedef struct packed {
    logic en;
    logic tick;
    logic ml;
    logic mr;
    exp_t x;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[27];
  int   total = 0;
  int   bad   = 0;
  int   ep    = 0;
  int   ee    = 0;
  logic edir  = 1'b0;

  function automatic vec_t mk(int en, int tick, int ml, int mr,
                              int p, int e, int r, int be, int d);
    vec_t v;
    v.en   = en[0];
    v.tick = tick[0];
    v.ml   = ml[0];
    v.mr   = mr[0];
    v.x.p  = W'(p);
    v.x.e  = W'(e);
    v.x.r  = r[0];
    v.x.be = be[0];
    v.x.d  = d[0];
    return v;
  endfunction

  function automatic exp_t cur(logic r, logic be);
    exp_t x;
    x.p  = W'(ep);
    x.e  = W'(ee);
    x.r  = r;
    x.be = be;
    x.d  = edir;
    return x;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input exp_t x);
    check({nm, ".p_score"},   8'(p_score),   8'(x.p));
    check({nm, ".e_score"},   8'(e_score),   8'(x.e));
    check({nm, ".ball_rst"},  8'(ball_rst),  8'(x.r));
    check({nm, ".ball_en"},   8'(ball_en),   8'(x.be));
    check({nm, ".serve_dir"}, 8'(serve_dir), 8'(x.d));
  endtask

  task automatic step(input logic en, input logic tick, input logic ml, input logic mr,
                      input string nm, input exp_t x);
    exp_t g;
    game_en    = en;
    frame_tick = tick;
    miss_left  = ml;
    miss_right = mr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check_outs(nm, g);
    frame_tick = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  task automatic serve_to_play();
    step(1'b1, 1'b1, 1'b0, 1'b0, "serve_t1", cur(1'b1, 1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b0, "serve_t2", cur(1'b1, 1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b0, "launch",   cur(1'b0, 1'b1));
  endtask

  task automatic miss(input logic ml, input logic mr, input logic tick);
    if (ml && ee < MAX_SCORE) ee++;
    if (mr && ep < MAX_SCORE) ep++;
    if (ml ^ mr) edir = mr;
    step(1'b1, tick, ml, mr, "miss", cur(1'b0, 1'b0));
  endtask

  task automatic hold_to_serve();
    step(1'b1, 1'b1, 1'b0, 1'b0, "hold_t1",  cur(1'b0, 1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b0, "hold_end", cur(1'b1, 1'b0));
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,0, 0,0,1,0,0);
    tbl[1]  = mk(1,0,0,0, 0,0,1,0,0);
    tbl[2]  = mk(1,1,0,0, 0,0,1,0,0);
    tbl[3]  = mk(1,0,0,0, 0,0,1,0,0);
    tbl[4]  = mk(1,1,0,0, 0,0,1,0,0);
    tbl[5]  = mk(1,1,0,0, 0,0,0,1,0);
    tbl[6]  = mk(1,1,0,0, 0,0,0,1,0);
    tbl[7]  = mk(1,1,0,1, 1,0,0,0,1);
    tbl[8]  = mk(1,1,0,0, 1,0,0,0,1);
    tbl[9]  = mk(1,0,1,0, 1,0,0,0,1);
    tbl[10] = mk(1,1,0,0, 1,0,1,0,1);
    tbl[11] = mk(1,1,0,0, 1,0,1,0,1);
    tbl[12] = mk(1,1,0,0, 1,0,1,0,1);
    tbl[13] = mk(1,1,0,0, 1,0,0,1,1);
    tbl[14] = mk(1,0,1,0, 1,1,0,0,0);
    tbl[15] = mk(1,1,0,0, 1,1,0,0,0);
    tbl[16] = mk(1,1,0,0, 1,1,1,0,0);
    tbl[17] = mk(1,1,0,0, 1,1,1,0,0);
    tbl[18] = mk(1,1,0,0, 1,1,1,0,0);
    tbl[19] = mk(1,1,0,0, 1,1,0,1,0);
    tbl[20] = mk(1,0,0,1, 2,1,0,0,1);
    tbl[21] = mk(1,1,0,0, 2,1,0,0,1);
    tbl[22] = mk(1,1,0,0, 2,1,1,0,1);
    tbl[23] = mk(1,1,0,0, 2,1,1,0,1);
    tbl[24] = mk(0,0,0,0, 2,1,1,0,1);
    tbl[25] = mk(0,1,1,1, 2,1,1,0,1);
    tbl[26] = mk(1,0,0,0, 0,0,1,0,0);

    rst        = 1'b1;
    game_en    = 1'b0;
    frame_tick = 1'b0;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", cur(1'b1, 1'b0));
    rst = 1'b0;

    // reach PLAY with a nonzero score, then reset asynchronously mid-rally
    step(1'b1, 1'b0, 1'b0, 1'b0, "enable", cur(1'b1, 1'b0));
    serve_to_play();
    miss(1'b0, 1'b1, 1'b0);
    hold_to_serve();
    serve_to_play();
    #2;
    rst = 1'b1;
    #1;
    ep = 0; ee = 0; edir = 1'b0;
    check_outs("async_rst", cur(1'b1, 1'b0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].en, tbl[i].tick, tbl[i].ml, tbl[i].mr, $sformatf("vec%0d", i), tbl[i].x);
    end
    ep = 0; ee = 0; edir = 1'b0;

    // build up to 2:2 with the player last scoring, then a double miss
    serve_to_play(); miss(1'b1, 1'b0, 1'b0); hold_to_serve();
    serve_to_play(); miss(1'b0, 1'b1, 1'b0); hold_to_serve();
    serve_to_play(); miss(1'b1, 1'b0, 1'b0); hold_to_serve();
    serve_to_play(); miss(1'b0, 1'b1, 1'b0); hold_to_serve();
    serve_to_play(); miss(1'b1, 1'b1, 1'b0); hold_to_serve();
    check("double_miss.p", 8'(p_score), 8'd3);
    check("double_miss.e", 8'(e_score), 8'd3);

    serve_to_play();
    while (ee < MAX_SCORE - 1) begin
      miss(1'b1, 1'b0, 1'b0);
      hold_to_serve();
      serve_to_play();
    end
    miss(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, "point_ignore", cur(1'b0, 1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b0, "final_t1",     cur(1'b0, 1'b0));
    step(1'b1, 1'b1, 1'b0, 1'b0, "final_idle",   cur(1'b1, 1'b0));
    step(1'b0, 1'b0, 1'b1, 1'b1, "idle_ignore",  cur(1'b1, 1'b0));
    check("max.e", 8'(e_score), 8'(MAX_SCORE));
    ep = 0; ee = 0; edir = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, "restart", cur(1'b1, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
